// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds the control FSM state encoding and the default parameter values
// (pipeline depth, stall source count, per-source stall depths, watchdog width).
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    CTRL_RUN   = 2'd0,
    CTRL_FENCE = 2'd1,
    CTRL_WFI   = 2'd2
  } ctrlState_t;

  localparam int DEF_STAGES  = 5;
  localparam int DEF_NREQ    = 4;
  localparam int DEF_DEPTH_W = 3;
  localparam int DEF_WDOG_W  = 8;

  // Source 0 stalls IF only; sources 1/2 stall IF+ID; source 3 stalls IF..EX.
  localparam logic [DEF_NREQ*DEF_DEPTH_W-1:0] DEF_REQ_DEPTH = {3'd3, 3'd2, 3'd2, 3'd1};

endpackage

// File: rtl/pipe_stall_depth_enc.sv
// Max-depth encoder plus thermometer for the pipeline stall requests.
// Ports:
//   stallReq  in   NREQ        per-source stall requests
//   depth     out  DEPTH_W     deepest stage count among asserted sources (0 if none)
//   stallMask out  STAGES      thermometer (1<<depth)-1, saturating at all stages
//   flushMask out  STAGES-1    one-hot bubble at boundary depth-1 (none for depth 0 or >= STAGES)
module pipe_stall_depth_enc
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int                          NREQ      = DEF_NREQ,
  parameter int                          DEPTH_W   = DEF_DEPTH_W,
  parameter int                          STAGES    = DEF_STAGES,
  parameter logic [NREQ*DEPTH_W-1:0]     REQ_DEPTH = DEF_REQ_DEPTH
) (
  input  logic [NREQ-1:0]    stallReq,
  output logic [DEPTH_W-1:0] depth,
  output logic [STAGES-1:0]  stallMask,
  output logic [STAGES-2:0]  flushMask
);

  always_comb begin
    depth = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (stallReq[i] && (REQ_DEPTH[i*DEPTH_W +: DEPTH_W] > depth)) begin
        depth = REQ_DEPTH[i*DEPTH_W +: DEPTH_W];
      end
    end
  end

  // Stages below the frozen depth hold; the bubble goes into the first
  // stage that keeps moving, i.e. boundary depth-1.
  always_comb begin
    stallMask = '0;
    flushMask = '0;
    for (int s = 0; s < STAGES; s++) begin
      stallMask[s] = (int'(depth) > s);
    end
    for (int b = 0; b < STAGES - 1; b++) begin
      flushMask[b] = (int'(depth) == b + 1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard / stall controller.
// Combines per-source stall requests, redirects, 16-bit realign, WFI and
// fence sequencing into per-stage hold and per-boundary bubble controls.
// Ports:
//   Clk, Rst_n          clock, asynchronous active-low reset
//   Stall_Req[NREQ]     per-source stall requests
//   Redirect_Req        branch/exception redirect (bubbles IF/ID and ID/EX, forces RUN)
//   Half_Flag           16-bit realign (bubbles IF/ID)
//   Wfi_Req, Wfi_Clr    WFI decoded / wake event
//   Fence_Req           fence decoded
//   LdSt_Busy[STAGES]   per-stage load/store present
//   Ctrl_Stall[STAGES]  per-stage hold, bit0 = IF (combinational)
//   Flush[STAGES-1]     per-boundary bubble, bit0 = IF/ID (combinational)
//   Ctrl_State[2]       registered FSM state
//   Ctrl_StallTimeout   registered watchdog flag
// Optional feature: define PIPE_CTRL_WATCHDOG_EN to build the stall watchdog;
// otherwise Ctrl_StallTimeout is tied low.
//
// state | meaning
// RUN   | normal flow, stalls follow the deepest stall request
// FENCE | IF/ID held until no load/store remains past IF
// WFI   | whole pipe held until wake or redirect
// (encoding 3 is unused and falls back to RUN)
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int                       STAGES    = DEF_STAGES,
  parameter int                       NREQ      = DEF_NREQ,
  parameter int                       DEPTH_W   = DEF_DEPTH_W,
  parameter logic [NREQ*DEPTH_W-1:0]  REQ_DEPTH = DEF_REQ_DEPTH,
  parameter int                       WDOG_W    = DEF_WDOG_W
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [NREQ-1:0]   Stall_Req,
  input  logic              Redirect_Req,
  input  logic              Half_Flag,
  input  logic              Wfi_Req,
  input  logic              Wfi_Clr,
  input  logic              Fence_Req,
  input  logic [STAGES-1:0] LdSt_Busy,
  output logic [STAGES-1:0] Ctrl_Stall,
  output logic [STAGES-2:0] Flush,
  output logic [1:0]        Ctrl_State,
  output logic              Ctrl_StallTimeout
);

  localparam logic [STAGES-1:0] FENCE_STALL    = STAGES'(2'b11);
  localparam logic [STAGES-2:0] FENCE_FLUSH    = (STAGES-1)'(2'b10);
  localparam logic [STAGES-2:0] REDIRECT_FLUSH = (STAGES-1)'(2'b11);

  ctrlState_t         state;
  ctrlState_t         nextState;
  logic [DEPTH_W-1:0] runDepth;
  logic [STAGES-1:0]  runStall;
  logic [STAGES-2:0]  runFlush;
  logic [STAGES-1:0]  stallMask;
  logic [STAGES-2:0]  flushMask;
  logic               busyDown;

  pipe_stall_depth_enc #(
    .NREQ      (NREQ),
    .DEPTH_W   (DEPTH_W),
    .STAGES    (STAGES),
    .REQ_DEPTH (REQ_DEPTH)
  ) uDepthEnc (
    .stallReq  (Stall_Req),
    .depth     (runDepth),
    .stallMask (runStall),
    .flushMask (runFlush)
  );

  // Only loads/stores already past IF matter for fence completion.
  assign busyDown = |LdSt_Busy[STAGES-1:1];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= CTRL_RUN;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    stallMask = '0;
    flushMask = '0;
    case (state)
      CTRL_RUN: begin
        stallMask = runStall;
        flushMask = runFlush;
        // A redirect cancels the WFI/fence that decoded alongside it.
        if (Redirect_Req) begin
          nextState = CTRL_RUN;
        end else if (Wfi_Req && !Wfi_Clr) begin
          stallMask = '1;
          flushMask = '0;
          nextState = CTRL_WFI;
        end else if (Fence_Req && busyDown) begin
          stallMask = runStall | FENCE_STALL;
          flushMask = runFlush | FENCE_FLUSH;
          nextState = CTRL_FENCE;
        end
      end
      CTRL_FENCE: begin
        stallMask = runStall;
        flushMask = runFlush;
        if (busyDown) begin
          stallMask = runStall | FENCE_STALL;
          flushMask = runFlush | FENCE_FLUSH;
        end else begin
          nextState = CTRL_RUN;
        end
      end
      CTRL_WFI: begin
        stallMask = '1;
        if (Wfi_Clr || Redirect_Req) begin
          nextState = CTRL_RUN;
        end
      end
      default: begin
        nextState = CTRL_RUN;
      end
    endcase
    if (Redirect_Req) begin
      flushMask = flushMask | REDIRECT_FLUSH;
      nextState = CTRL_RUN;
    end
    if (Half_Flag) begin
      flushMask[0] = 1'b1;
    end
  end

  assign Ctrl_Stall = stallMask;
  assign Flush      = flushMask;
  assign Ctrl_State = state;

`ifdef PIPE_CTRL_WATCHDOG_EN
  logic [WDOG_W-1:0] wdogCnt;
  logic              wdogTimeout;
  logic              wdogHit;

  // WFI is an intentional hold, so it never counts toward the timeout.
  assign wdogHit = stallMask[0] && (state != CTRL_WFI);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wdogCnt     <= '0;
      wdogTimeout <= 1'b0;
    end else begin
      if (!wdogHit) begin
        wdogCnt <= '0;
      end else if (wdogCnt != '1) begin
        wdogCnt <= wdogCnt + 1'b1;
      end
      // Drops the cycle after the stall releases.
      wdogTimeout <= wdogHit && (wdogCnt == '1);
    end
  end

  assign Ctrl_StallTimeout = wdogTimeout;
`else
  assign Ctrl_StallTimeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int STAGES = 5;
  localparam int NREQ   = 4;

  logic              Clk = 1'b0;
  logic              Rst_n;
  logic [NREQ-1:0]   Stall_Req;
  logic              Redirect_Req;
  logic              Half_Flag;
  logic              Wfi_Req;
  logic              Wfi_Clr;
  logic              Fence_Req;
  logic [STAGES-1:0] LdSt_Busy;
  logic [STAGES-1:0] Ctrl_Stall;
  logic [STAGES-2:0] Flush;
  logic [1:0]        Ctrl_State;
  logic              Ctrl_StallTimeout;

  int testCount = 0;
  int failCount = 0;
  int fenceStallCycles;

  pipe_hazard_ctrl #(
    .STAGES  (STAGES),
    .NREQ    (NREQ),
    .DEPTH_W (3),
    .REQ_DEPTH ({3'd3, 3'd2, 3'd2, 3'd1}),
    .WDOG_W  (4)
  ) dut (
    .Clk               (Clk),
    .Rst_n             (Rst_n),
    .Stall_Req         (Stall_Req),
    .Redirect_Req      (Redirect_Req),
    .Half_Flag         (Half_Flag),
    .Wfi_Req           (Wfi_Req),
    .Wfi_Clr           (Wfi_Clr),
    .Fence_Req         (Fence_Req),
    .LdSt_Busy         (LdSt_Busy),
    .Ctrl_Stall        (Ctrl_Stall),
    .Flush             (Flush),
    .Ctrl_State        (Ctrl_State),
    .Ctrl_StallTimeout (Ctrl_StallTimeout)
  );

  always #5 Clk = ~Clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic idleInputs();
    Stall_Req    = '0;
    Redirect_Req = 1'b0;
    Half_Flag    = 1'b0;
    Wfi_Req      = 1'b0;
    Wfi_Clr      = 1'b0;
    Fence_Req    = 1'b0;
    LdSt_Busy    = '0;
  endtask

  // Inputs change on the falling edge; checks follow 1 time unit later.
  task automatic nextCycle();
    @(negedge Clk);
  endtask

  logic [3:0] reqTab   [6] = '{4'b0101, 4'b1000, 4'b0001, 4'b0110, 4'b1111, 4'b0000};
  logic [4:0] stallTab [6] = '{5'b00011, 5'b00111, 5'b00001, 5'b00011, 5'b00111, 5'b00000};
  logic [3:0] flushTab [6] = '{4'b0010, 4'b0100, 4'b0001, 4'b0010, 4'b0100, 4'b0000};

  initial begin
    logic expTo;
    idleInputs();
    Rst_n = 1'b0;
    #12;
    checkVal("rst_state",   32'(Ctrl_State),        'd0);
    checkVal("rst_stall",   32'(Ctrl_Stall),        'd0);
    checkVal("rst_flush",   32'(Flush),             'd0);
    checkVal("rst_timeout", 32'(Ctrl_StallTimeout), 'd0);
    nextCycle();
    Rst_n = 1'b1;

    // Depth encoder / thermometer vectors
    for (int i = 0; i < 6; i++) begin
      nextCycle();
      idleInputs();
      Stall_Req = reqTab[i];
      #1;
      checkVal("run_stall", 32'(Ctrl_Stall), 32'(stallTab[i]));
      checkVal("run_flush", 32'(Flush),      32'(flushTab[i]));
      checkVal("run_state", 32'(Ctrl_State), 'd0);
    end

    // Half-word realign ORs IF/ID bubble
    nextCycle();
    idleInputs();
    Stall_Req = 4'b0101;
    Half_Flag = 1'b1;
    #1;
    checkVal("half_flush", 32'(Flush),      'b0011);
    checkVal("half_stall", 32'(Ctrl_Stall), 'b00011);

    // Fence with only IF busy completes immediately
    nextCycle();
    idleInputs();
    Fence_Req = 1'b1;
    LdSt_Busy = 5'b00001;
    #1;
    checkVal("fence_idle_stall", 32'(Ctrl_Stall), 'd0);
    checkVal("fence_idle_flush", 32'(Flush),      'd0);
    nextCycle();
    idleInputs();
    #1;
    checkVal("fence_idle_state", 32'(Ctrl_State), 'd0);

    // Fence with MEM busy: entry cycle + 3 held cycles, release on busy drop
    fenceStallCycles = 0;
    nextCycle();
    idleInputs();
    Fence_Req = 1'b1;
    LdSt_Busy = 5'b01000;
    #1;
    checkVal("fence_entry_stall", 32'(Ctrl_Stall), 'b00011);
    checkVal("fence_entry_flush", 32'(Flush),      'b0010);
    checkVal("fence_entry_state", 32'(Ctrl_State), 'd0);
    if (Ctrl_Stall[1:0] == 2'b11) fenceStallCycles++;
    for (int c = 1; c <= 3; c++) begin
      nextCycle();
      Fence_Req = 1'b0;
      Stall_Req = (c == 2) ? 4'b1000 : 4'b0000;
      #1;
      checkVal("fence_hold_state", 32'(Ctrl_State), 'd1);
      checkVal("fence_hold_stall", 32'(Ctrl_Stall), (c == 2) ? 'b00111 : 'b00011);
      checkVal("fence_hold_flush", 32'(Flush),      (c == 2) ? 'b0110 : 'b0010);
      if (Ctrl_Stall[1:0] == 2'b11) fenceStallCycles++;
    end
    nextCycle();
    idleInputs();
    #1;
    checkVal("fence_rel_stall", 32'(Ctrl_Stall), 'd0);
    checkVal("fence_rel_flush", 32'(Flush),      'd0);
    checkVal("fence_rel_state", 32'(Ctrl_State), 'd1);
    if (Ctrl_Stall[1:0] == 2'b11) fenceStallCycles++;
    nextCycle();
    #1;
    checkVal("fence_done_state", 32'(Ctrl_State), 'd0);
    checkVal("fence_stall_cycles", 32'(fenceStallCycles), 'd4);

    // WFI: enter at cycle 0, wake at cycle 10, RUN at cycle 11
    nextCycle();
    idleInputs();
    Wfi_Req = 1'b1;
    #1;
    checkVal("wfi_entry_stall", 32'(Ctrl_Stall), 'b11111);
    checkVal("wfi_entry_flush", 32'(Flush),      'd0);
    checkVal("wfi_entry_state", 32'(Ctrl_State), 'd0);
    for (int c = 1; c <= 10; c++) begin
      nextCycle();
      Wfi_Req   = 1'b0;
      Wfi_Clr   = (c == 10);
      Stall_Req = (c == 5) ? 4'b1111 : 4'b0000;
      #1;
      checkVal("wfi_hold_stall", 32'(Ctrl_Stall), 'b11111);
      checkVal("wfi_hold_flush", 32'(Flush),      'd0);
      checkVal("wfi_hold_state", 32'(Ctrl_State), 'd2);
    end
    nextCycle();
    idleInputs();
    #1;
    checkVal("wfi_exit_state", 32'(Ctrl_State), 'd0);
    checkVal("wfi_exit_stall", 32'(Ctrl_Stall), 'd0);

    // WFI request with wake already present does not enter
    nextCycle();
    Wfi_Req = 1'b1;
    Wfi_Clr = 1'b1;
    #1;
    checkVal("wfi_clr_stall", 32'(Ctrl_Stall), 'd0);
    nextCycle();
    idleInputs();
    #1;
    checkVal("wfi_clr_state", 32'(Ctrl_State), 'd0);

    // Redirect beats fence entry
    nextCycle();
    Redirect_Req = 1'b1;
    Fence_Req    = 1'b1;
    LdSt_Busy    = 5'b01000;
    #1;
    checkVal("redir_fence_flush", 32'(Flush),      'b0011);
    checkVal("redir_fence_stall", 32'(Ctrl_Stall), 'd0);
    nextCycle();
    idleInputs();
    #1;
    checkVal("redir_fence_state", 32'(Ctrl_State), 'd0);

    // Redirect beats WFI entry
    nextCycle();
    Redirect_Req = 1'b1;
    Wfi_Req      = 1'b1;
    #1;
    checkVal("redir_wfi_flush", 32'(Flush), 'b0011);
    nextCycle();
    idleInputs();
    #1;
    checkVal("redir_wfi_state", 32'(Ctrl_State), 'd0);

    // Redirect wakes WFI
    nextCycle();
    Wfi_Req = 1'b1;
    nextCycle();
    idleInputs();
    #1;
    checkVal("wfi_redir_pre_state", 32'(Ctrl_State), 'd2);
    Redirect_Req = 1'b1;
    #1;
    checkVal("wfi_redir_flush", 32'(Flush),      'b0011);
    checkVal("wfi_redir_stall", 32'(Ctrl_Stall), 'b11111);
    nextCycle();
    idleInputs();
    #1;
    checkVal("wfi_redir_state", 32'(Ctrl_State), 'd0);
    checkVal("wfi_redir_rel",   32'(Ctrl_Stall), 'd0);

    // Watchdog: IF stalled for cycles 0..19 with a 4-bit counter
    nextCycle();
    idleInputs();
    for (int k = 0; k <= 21; k++) begin
      nextCycle();
      Stall_Req = (k < 20) ? 4'b0001 : 4'b0000;
      #1;
`ifdef PIPE_CTRL_WATCHDOG_EN
      expTo = (k >= 16) && (k <= 20);
`else
      expTo = 1'b0;
`endif
      checkVal($sformatf("wdog_timeout_c%0d", k), 32'(Ctrl_StallTimeout), 32'(expTo));
    end

    // Reset in the middle of a fence
    nextCycle();
    idleInputs();
    Fence_Req = 1'b1;
    LdSt_Busy = 5'b01000;
    nextCycle();
    Fence_Req = 1'b0;
    #1;
    checkVal("rstfence_pre_state", 32'(Ctrl_State), 'd1);
    checkVal("rstfence_pre_stall", 32'(Ctrl_Stall), 'b00011);
    #1;
    Rst_n = 1'b0;
    #1;
    checkVal("rstfence_state", 32'(Ctrl_State), 'd0);
    checkVal("rstfence_stall", 32'(Ctrl_Stall), 'd0);
    checkVal("rstfence_flush", 32'(Flush),      'd0);
    nextCycle();
    Rst_n = 1'b1;
    nextCycle();
    #1;
    checkVal("rstfence_post_state", 32'(Ctrl_State), 'd0);
    checkVal("rstfence_post_stall", 32'(Ctrl_Stall), 'd0);
    idleInputs();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
